fifo_frame_reader: RTL and testbench

Read-side consumer for the asynchronous FIFO, running in the read clock domain. It drains bytes from the FIFO's show-ahead read port and groups them into frames of FRAME_LEN data bytes. After each frame it appends one XOR checksum byte. The result is presented on a registered valid/ready byte stream with an end-of-frame flag, for the downstream serializer.

---
 rtl/fifo_frame_reader.sv | 144 ++++++++++++++
 tb/tb_fifo_frame_reader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_reader.sv
// Read-side frame builder: drains a show-ahead FIFO into frames of FRAME_LEN bytes,
// appends an XOR checksum byte and presents the result on a registered valid/ready stream.
module fifo_frame_reader #(
    parameter int unsigned FRAME_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CHK  = 2'd2
    } state_t;

    // byte_cnt value seen on the pop that completes a frame
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  byte_cnt_r;
    logic [7:0]  chk_r;
    logic [15:0] frame_cnt_r;
    logic [7:0]  m_data_r;
    logic        m_valid_r;
    logic        m_last_r;
    logic        slot_free_s;
    logic        pop_s;
    logic        chk_load_s;

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    assign slot_free_s = ~m_valid_r | m_ready;

    // Next-state decode plus the pop and checksum-load strobes
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        chk_load_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                pop_s = ~fifo_empty & slot_free_s;
                if (pop_s && (byte_cnt_r == LAST_IDX)) begin
                    state_next_s = ST_CHK;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_CHK: begin
                chk_load_s = slot_free_s;
                if (slot_free_s) begin
                    // en is only honoured here, so a started frame always finishes
                    state_next_s = en ? ST_DATA : ST_IDLE;
                end else begin
                    state_next_s = ST_CHK;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame bookkeeping: byte position, running checksum, completed-frame count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt_r  <= 4'd0;
            chk_r       <= 8'h00;
            frame_cnt_r <= 16'h0000;
        end else if (pop_s) begin
            byte_cnt_r <= byte_cnt_r + 4'd1;
            chk_r      <= chk_update(chk_r, fifo_dout);
        end else if (chk_load_s) begin
            byte_cnt_r  <= 4'd0;
            chk_r       <= 8'h00;
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            byte_cnt_r  <= byte_cnt_r;
            chk_r       <= chk_r;
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Output slot: a load may replace an accepted byte in the same cycle without a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data_r  <= 8'h00;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else if (pop_s) begin
            m_data_r  <= fifo_dout;
            m_valid_r <= 1'b1;
            m_last_r  <= 1'b0;
        end else if (chk_load_s) begin
            m_data_r  <= chk_r;
            m_valid_r <= 1'b1;
            m_last_r  <= 1'b1;
        end else if (m_valid_r && m_ready) begin
            m_data_r  <= m_data_r;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else begin
            m_data_r  <= m_data_r;
            m_valid_r <= m_valid_r;
            m_last_r  <= m_last_r;
        end
    end

    assign fifo_rd_en = pop_s;
    assign m_data     = m_data_r;
    assign m_valid    = m_valid_r;
    assign m_last     = m_last_r;
    assign frame_cnt  = frame_cnt_r;
    assign busy       = (state_r != ST_IDLE) | m_valid_r;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: a queue-based FIFO and a byte-stream reference model
// (data bytes grouped into frames followed by their XOR) check every accepted output byte.
module tb_fifo_frame_reader;

    localparam int FL    = 4;
    localparam int BOUND = 300;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [15:0] frame_cnt;
    logic        busy;

    fifo_frame_reader #(.FRAME_LEN(FL)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         total_cnt = 0;
    int         pass_cnt  = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_data_q[$];
    logic       exp_last_q[$];
    int         in_frame;
    logic [7:0] acc;
    int         frames_exp;
    int         cyc;
    int         scen_pops;
    int         scen_first;
    int         scen_last;
    bit         prev_pop;
    logic [7:0] prev_pop_byte;
    bit         prev_hold;
    logic [7:0] prev_data;
    logic       prev_last;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? 8'hEE : fifo_q[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        drive_fifo();
    endtask

    // Reference stream: each popped byte is emitted, and every FL bytes their XOR follows with last set
    task automatic model_pop(input logic [7:0] b);
        exp_data_q.push_back(b);
        exp_last_q.push_back(1'b0);
        acc = acc ^ b;
        in_frame++;
        if (in_frame == FL) begin
            exp_data_q.push_back(acc);
            exp_last_q.push_back(1'b1);
            acc        = 8'h00;
            in_frame   = 0;
            frames_exp = (frames_exp + 1) % 65536;
        end
    endtask

    task automatic clear_model();
        exp_data_q.delete();
        exp_last_q.delete();
        fifo_q.delete();
        in_frame   = 0;
        acc        = 8'h00;
        frames_exp = 0;
        prev_pop   = 1'b0;
        prev_hold  = 1'b0;
        drive_fifo();
    endtask

    task automatic start_scen();
        scen_pops  = 0;
        scen_first = -1;
        scen_last  = -1;
    endtask

    // One clock cycle: sample and check outputs, then apply the FIFO pop after the edge
    task automatic tick();
        bit         rd;
        logic [7:0] b;
        #1;
        rd = fifo_rd_en;
        if (prev_pop) begin
            check("latency_valid", m_valid, 1);
            check("latency_data", m_data, prev_pop_byte);
            check("latency_last", m_last, 0);
        end
        if (prev_hold) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, prev_data);
            check("hold_last", m_last, prev_last);
        end
        if (rd) begin
            check("pop_while_empty", fifo_empty, 0);
            check("pop_slot_free", (!m_valid || m_ready), 1);
        end
        if (m_valid) check("busy_with_valid", busy, 1);
        if (m_valid && m_ready) begin
            if (exp_data_q.size() == 0) begin
                check("unexpected_byte", m_valid, 0);
            end else begin
                check("out_data", m_data, exp_data_q.pop_front());
                check("out_last", m_last, exp_last_q.pop_front());
            end
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
        prev_last = m_last;
        @(posedge clk);
        #1;
        cyc++;
        prev_pop = 1'b0;
        if (rd && fifo_q.size() > 0) begin
            b = fifo_q.pop_front();
            model_pop(b);
            prev_pop      = 1'b1;
            prev_pop_byte = b;
            scen_pops++;
            if (scen_first < 0) scen_first = cyc;
            scen_last = cyc;
        end
        drive_fifo();
        @(negedge clk);
    endtask

    task automatic drain(input bit rnd_ready, input string tag);
        int n;
        n = 0;
        while (!(exp_data_q.size() == 0 && in_frame == 0 && (fifo_q.size() == 0 || !en))
               && n < BOUND) begin
            m_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            n++;
        end
        check({tag, "_drain_timeout"}, (n < BOUND), 1);
        m_ready = 1'b1;
    endtask

    task automatic wait_pops(input int k, input string tag);
        int n;
        n = 0;
        while (scen_pops < k && n < BOUND) begin
            tick();
            n++;
        end
        check({tag, "_pop_timeout"}, (n < BOUND), 1);
    endtask

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        m_ready = 1'b1;
        cyc     = 0;
        clear_model();
        start_scen();
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_frame_cnt", frame_cnt, 16'h0000);
        check("rst_busy", busy, 0);

        // Basic frame; data and en present while still in reset must not pop
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        en = 1'b1;
        #1;
        check("rst_rd_en", fifo_rd_en, 0);
        @(negedge clk);
        reset = 1'b0;
        drain(1'b0, "basic");
        check("basic_frame_cnt", frame_cnt, frames_exp[15:0]);
        repeat (3) tick();
        check("basic_no_extra_pop", scen_pops, FL);

        // Backpressure after the first byte
        start_scen();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_pops(1, "bp");
        m_ready = 1'b0;
        repeat (3) begin
            #1;
            check("bp_data", m_data, 8'h11);
            check("bp_valid", m_valid, 1);
            check("bp_rd_en", fifo_rd_en, 0);
            tick();
        end
        check("bp_pops", scen_pops, 1);
        drain(1'b0, "bp");
        check("bp_frame_cnt", frame_cnt, frames_exp[15:0]);

        // Starved FIFO mid-frame
        start_scen();
        push(8'h5A); push(8'hC3);
        wait_pops(2, "starve");
        repeat (5) begin
            tick();
            check("starve_rd_en", fifo_rd_en, 0);
            check("starve_busy", busy, 1);
        end
        push(8'h0F); push(8'hF0);
        drain(1'b0, "starve");
        check("starve_frame_cnt", frame_cnt, frames_exp[15:0]);

        // Back-to-back frames: 8 pops over 9 cycles means exactly one gap
        start_scen();
        for (int i = 1; i <= 8; i++) push(8'(i));
        drain(1'b0, "b2b");
        check("b2b_pops", scen_pops, 2 * FL);
        check("b2b_span", scen_last - scen_first + 1, 2 * FL + 1);
        check("b2b_frame_cnt", frame_cnt, frames_exp[15:0]);

        // en dropped during byte 2: frame completes, then idle with data still queued
        start_scen();
        for (int i = 0; i < 8; i++) push(8'($urandom_range(0, 255)));
        wait_pops(2, "en");
        en = 1'b0;
        drain(1'b0, "en");
        check("en_busy", busy, 0);
        check("en_rd_en", fifo_rd_en, 0);
        repeat (3) begin
            tick();
            check("en_idle_rd_en", fifo_rd_en, 0);
        end
        check("en_fifo_left", fifo_q.size(), FL);
        check("en_frame_cnt", frame_cnt, frames_exp[15:0]);

        // Reset after two pops of the queued frame
        start_scen();
        en = 1'b1;
        wait_pops(2, "rstmid");
        reset = 1'b1;
        #1;
        check("rstmid_valid", m_valid, 0);
        check("rstmid_frame_cnt", frame_cnt, 16'h0000);
        check("rstmid_busy", busy, 0);
        clear_model();
        tick();
        reset = 1'b0;
        for (int i = 0; i < FL; i++) push(8'($urandom_range(0, 255)));
        drain(1'b0, "rstmid");
        check("rstmid_frame_cnt_after", frame_cnt, frames_exp[15:0]);

        // Random data trickling in with random downstream readiness
        start_scen();
        begin
            int pushed;
            pushed = 0;
            for (int c = 0; c < 120; c++) begin
                if (pushed < 12 * FL && $urandom_range(0, 2) != 0) begin
                    push(8'($urandom_range(0, 255)));
                    pushed++;
                end
                m_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            while (pushed < 12 * FL) begin
                push(8'($urandom_range(0, 255)));
                pushed++;
            end
        end
        drain(1'b1, "rand");
        check("rand_frame_cnt", frame_cnt, frames_exp[15:0]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
